// File: rtl/sha256_sched_pkg.sv
// sha256_sched_pkg
// Shared types and default widths for the SHA-256 job scheduler slice.
// Contents:
//   sched_state_t            : job FSM states (IDLE, LAUNCH, RUN, DONE)
//   DEF_ADDR_W / DEF_DATA_W  : default memory address / data widths
package sha256_sched_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick. It grants the first requester at or
// after the pointer, wrapping modulo N. The caller owns the pointer register.
// Ports:
//   i_req   [N]   request vector
//   i_ptr   [IW]  highest-priority index this cycle (must be < N)
//   o_gnt   [N]   one-hot grant, all zero when nothing requests
//   o_idx   [IW]  encoded index of the granted requester
//   o_valid       a grant was issued
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value held and infer a latch.
  always_comb begin
    int j;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_valid && i_req[j]) begin
        o_valid  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler
// Runs one hashing job across NUM_CORES SHA-256 cores. It issues staggered
// core_start pulses and collects per-core completion into one done level. It
// also owns the single memory port, which the cores share through a pipelined
// round-robin arbiter.
// Optional build macro: SCHED_WATCHDOG_EN. When it is defined, a RUN-cycle
// watchdog ends the job after TIMEOUT_CYCLES with timeout=1. When it is not
// defined, timeout is tied to 0.
// Ports:
//   clk, reset(async, active-high), start(pulse) -> done, timeout (levels)
//   core_start/core_done   : per-core launch pulse / completion level
//   core_req/we/addr/wdata : per-core memory requests (addr/wdata packed)
//   core_gnt               : combinational one-hot grant
//   core_rdata/core_rvalid : broadcast read data / one-hot valid strobe
//   mem_*                  : single-port synchronous memory (1-cycle read)
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int STAGGER        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        done,
  output logic                        timeout,
  output logic [NUM_CORES-1:0]        core_start,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic                        mem_clk,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_write_data,
  input  logic [DATA_W-1:0]           mem_read_data
);

  localparam int IW = $clog2(NUM_CORES);
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  if (NUM_CORES < 2 || NUM_CORES > 16 || STAGGER < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sha256_job_scheduler: parameter out of range");
  end

  sched_state_t         r_state, w_next;
  logic [IW-1:0]        r_idx;
  logic [SW-1:0]        r_wait;
  logic [NUM_CORES-1:0] r_started, r_finished, r_done_prev;
  logic [NUM_CORES-1:0] w_rise;
  logic                 w_clear, w_wd_expire;

  logic [IW-1:0]        r_rr_ptr, w_gnt_idx;
  logic                 w_accept;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [NUM_CORES-1:0] r_rd_pend, r_rvalid;

  // A done edge counts only for cores started in an earlier cycle. A core
  // whose done rises in its own start cycle is therefore ignored.
  assign w_rise = core_done & ~r_done_prev;

  // ---------------- job FSM: next state and outputs ----------------
  always_comb begin
    w_next     = r_state;
    core_start = '0;
    w_clear    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next  = LAUNCH;
          w_clear = 1'b1;
        end
      end
      LAUNCH: begin
        if (r_wait == '0) begin
          core_start[r_idx] = 1'b1;
          if (r_idx == IW'(NUM_CORES - 1)) w_next = RUN;
        end
      end
      RUN: begin
        if (&r_finished || w_wd_expire) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_wait      <= '0;
      r_started   <= '0;
      r_finished  <= '0;
      r_done_prev <= '0;
    end else begin
      r_state     <= w_next;
      r_done_prev <= core_done;
      if (w_clear) begin
        r_idx      <= '0;
        r_wait     <= '0;
        r_started  <= '0;
        r_finished <= '0;
      end else begin
        if (r_state == LAUNCH) begin
          if (r_wait == '0) begin
            r_started <= r_started | core_start;
            r_idx     <= r_idx + 1'b1;
            r_wait    <= SW'(STAGGER - 1);
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        if (r_state == LAUNCH || r_state == RUN)
          r_finished <= r_finished | (w_rise & r_started);
      end
    end
  end

  assign done = (r_state == DONE);

`ifdef SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wd_cnt;
  logic          r_timeout;

  // The counter idles at zero outside RUN, so it is always cleared on RUN
  // entry. Expiry on count TIMEOUT_CYCLES-1 puts DONE exactly TIMEOUT_CYCLES
  // cycles after entry.
  assign w_wd_expire = (r_state == RUN) && (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= (r_state == RUN) ? r_wd_cnt + 1'b1 : '0;
      if (w_clear)                          r_timeout <= 1'b0;
      else if (w_wd_expire && !(&r_finished)) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  // ---------------- memory arbiter and request pipeline ----------------
  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .i_req   (core_req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (core_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_accept)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_pend   <= '0;
      r_rvalid    <= '0;
    end else begin
      r_rvalid <= r_rd_pend;
      if (w_accept) begin
        r_mem_we    <= core_we[w_gnt_idx];
        r_mem_addr  <= core_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        r_mem_wdata <= core_wdata[w_gnt_idx*DATA_W +: DATA_W];
        r_rr_ptr    <= (w_gnt_idx == IW'(NUM_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_rd_pend   <= core_we[w_gnt_idx] ? '0 : core_gnt;
      end else begin
        r_mem_we  <= 1'b0;
        r_rd_pend <= '0;
      end
    end
  end

  assign mem_clk        = clk;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign core_rdata     = mem_read_data;
  assign core_rvalid    = r_rvalid;

endmodule
